lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_store_fifo.sv | 47 ++++
 rtl/lsu.sv | 189 ++++++++++++++++++
 tb/tb_lsu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size codes and FSM states.
package lsu_pkg;

    // Access size carried on memcnf_i / mcnf_o
    localparam logic [1:0] CNF_NONE = 2'd0;
    localparam logic [1:0] CNF_B    = 2'd1;
    localparam logic [1:0] CNF_H    = 2'd2;
    localparam logic [1:0] CNF_W    = 2'd3;

    // Request FSM states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ST_BUSY = 2'd1;
    localparam logic [1:0] S_LD_BUSY = 2'd2;

endpackage

// File: rtl/lsu_store_fifo.sv
// FIFO store buffer. Pointers carry one extra wrap bit so full and empty are
// both derived from registered pointers only.
module lsu_store_fifo #(
    parameter int SB_DEPTH = 4,
    parameter int ENTRY_W  = 66
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PW = $clog2(SB_DEPTH);

    logic [PW:0]        wr_q;
    logic [PW:0]        rd_q;
    logic [ENTRY_W-1:0] mem_q [SB_DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q[PW-1:0]];

    // Pointer update; low bits wrap modulo SB_DEPTH naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Entry storage; contents are irrelevant while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit. Stores are posted into a FIFO store buffer and drained to
// the memory controller one at a time; loads wait for the buffer to drain and
// then issue their own request. Non-memory ops pass through with one cycle of
// latency.
//
// Handshake: an op is accepted on a rising edge where valid_i=1 and
// mem_stall=0; EX must hold every input stable while mem_stall=1. Toward the
// memory controller, mreq_o and its fields stay stable until the cycle in
// which mdone_i=1 is sampled, which completes the request.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [REG_W-1:0]  wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] memaddr_i,
    input  logic              memwr_i,
    input  logic [1:0]        memcnf_i,
    input  logic              memsigned_i,
    output logic              mem_stall,
    output logic              valid_o,
    output logic [REG_W-1:0]  wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              mreq_o,
    output logic [ADDR_W-1:0] maddr_o,
    output logic              mwr_o,
    output logic [DATA_W-1:0] mdata_o,
    output logic [1:0]        mcnf_o,
    input  logic              mdone_i,
    input  logic [DATA_W-1:0] mdata_i
);

    localparam int ENT_W = ADDR_W + DATA_W + 2;

    logic [1:0]        state_q, state_d;
    logic              is_mem, is_store, is_load;
    logic              accept, ld_start;
    logic              sb_push, sb_pop, sb_full, sb_empty;
    logic [ENT_W-1:0]  sb_head;
    logic              mreq_q, mwr_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mdata_q;
    logic [1:0]        mcnf_q;
    logic [REG_W-1:0]  ld_wd_q;
    logic              ld_wreg_q, ld_signed_q;
    logic [DATA_W-1:0] ld_ext;
    logic              valid_q, wreg_q;
    logic [REG_W-1:0]  wd_q;
    logic [DATA_W-1:0] wdata_q;

    assign is_mem   = (memcnf_i != CNF_NONE);
    assign is_store = is_mem && memwr_i;
    assign is_load  = is_mem && !memwr_i;

    // Stall decision: only registered state and current inputs, never mdone_i
    always_comb begin
        mem_stall = 1'b0;
        if (!rst && valid_i) begin
            if (state_q == S_LD_BUSY)
                mem_stall = 1'b1;
            else if (is_store)
                mem_stall = sb_full;
            else if (is_load)
                mem_stall = !sb_empty || (state_q != S_IDLE);
        end
    end

    assign accept   = valid_i && !mem_stall && !rst;
    assign ld_start = accept && is_load;
    assign sb_push  = accept && is_store;
    assign sb_pop   = (state_q == S_ST_BUSY) && mdone_i;

    lsu_store_fifo #(
        .SB_DEPTH (SB_DEPTH),
        .ENTRY_W  (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sb_push),
        .data_i  ({memaddr_i, wdata_i, memcnf_i}),
        .pop_i   (sb_pop),
        .head_o  (sb_head),
        .full_o  (sb_full),
        .empty_o (sb_empty)
    );

    // Next state: a load that is allowed to proceed wins; otherwise drain stores
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ld_start)
                    state_d = S_LD_BUSY;
                else if (!sb_empty)
                    state_d = S_ST_BUSY;
            end
            S_ST_BUSY: if (mdone_i) state_d = S_IDLE;
            S_LD_BUSY: if (mdone_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register and memory-request fields, held stable while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mreq_q      <= 1'b0;
            mwr_q       <= 1'b0;
            maddr_q     <= '0;
            mdata_q     <= '0;
            mcnf_q      <= CNF_NONE;
            ld_wd_q     <= '0;
            ld_wreg_q   <= 1'b0;
            ld_signed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                if (ld_start) begin
                    mreq_q      <= 1'b1;
                    mwr_q       <= 1'b0;
                    maddr_q     <= memaddr_i;
                    mdata_q     <= '0;
                    mcnf_q      <= memcnf_i;
                    ld_wd_q     <= wd_i;
                    ld_wreg_q   <= wreg_i;
                    ld_signed_q <= memsigned_i;
                end else if (!sb_empty) begin
                    mreq_q                     <= 1'b1;
                    mwr_q                      <= 1'b1;
                    {maddr_q, mdata_q, mcnf_q} <= sb_head;
                end
            end else if (mdone_i) begin
                mreq_q <= 1'b0;
            end
        end
    end

    // Load data extension by access size
    always_comb begin
        case (mcnf_q)
            CNF_B:   ld_ext = {{(DATA_W-8){ld_signed_q & mdata_i[7]}}, mdata_i[7:0]};
            CNF_H:   ld_ext = {{(DATA_W-16){ld_signed_q & mdata_i[15]}}, mdata_i[15:0]};
            default: ld_ext = mdata_i;
        endcase
    end

    // Writeback register: load completion or a just-accepted non-load op
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if ((state_q == S_LD_BUSY) && mdone_i) begin
                valid_q <= 1'b1;
                wd_q    <= ld_wd_q;
                wreg_q  <= ld_wreg_q;
                wdata_q <= ld_ext;
            end else if (accept && !is_load) begin
                valid_q <= 1'b1;
                wd_q    <= wd_i;
                wreg_q  <= wreg_i && !is_store;
                wdata_q <= wdata_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;
    assign mreq_o  = mreq_q;
    assign maddr_o = maddr_q;
    assign mwr_o   = mwr_q;
    assign mdata_o = mdata_q;
    assign mcnf_o  = mcnf_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: random ops plus directed corner cases, with a
// scoreboard for writeback results and one for memory requests.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] memaddr_i;
  logic        memwr_i;
  logic [1:0]  memcnf_i;
  logic        memsigned_i;
  logic        mem_stall;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        mreq_o;
  logic [31:0] maddr_o;
  logic        mwr_o;
  logic [31:0] mdata_o;
  logic [1:0]  mcnf_o;
  logic        mdone_i;
  logic [31:0] mdata_i;

  logic        mdone_resp;
  logic        mdone_man;
  logic [31:0] mdata_resp;

  assign mdone_i = mdone_resp | mdone_man;
  assign mdata_i = mdone_man ? 32'hDEAD_BEEF : mdata_resp;

  lsu #(.ADDR_W(32), .DATA_W(32), .REG_W(5), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .memaddr_i(memaddr_i), .memwr_i(memwr_i),
    .memcnf_i(memcnf_i), .memsigned_i(memsigned_i), .mem_stall(mem_stall),
    .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .mreq_o(mreq_o), .maddr_o(maddr_o), .mwr_o(mwr_o), .mdata_o(mdata_o),
    .mcnf_o(mcnf_o), .mdone_i(mdone_i), .mdata_i(mdata_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [38:0] exp_q[$];      // {is_store, wreg, wd, wdata}
  logic [66:0] exp_mem_q[$];  // {wr, cnf, addr, data}
  logic [31:0] ld_data_q[$];  // data the memory returns for each load
  bit hold_off = 1'b1;
  int fixed_delay = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // reference: extend returned data by access size using plain arithmetic
  function automatic logic [31:0] ref_ext(input logic [1:0] cnf, input bit sgn, input logic [31:0] d);
    logic [31:0] v;
    case (cnf)
      2'd1: begin v = d % 256;   if (sgn && v >= 128)   v = v - 256;   end
      2'd2: begin v = d % 65536; if (sgn && v >= 32768) v = v - 65536; end
      default: v = d;
    endcase
    return v;
  endfunction

  // driver: present one op and hold it until accepted
  task automatic issue(input logic [1:0] cnf, input bit wr, input bit sgn, input logic [4:0] wd,
                       input bit wreg, input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] ld_data);
    int waited = 0;
    bit ok = 1'b0;
    valid_i = 1'b1; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    memaddr_i = addr; memwr_i = wr; memcnf_i = cnf; memsigned_i = sgn;
    while (!ok && waited < 400) begin
      @(negedge clk);
      if (!mem_stall) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      if (cnf == 2'd0) begin
        exp_q.push_back({1'b0, wreg, wd, wdata});
      end else if (wr) begin
        exp_q.push_back({1'b1, 1'b0, wd, wdata});
        exp_mem_q.push_back({1'b1, cnf, addr, wdata});
      end else begin
        exp_q.push_back({1'b0, wreg, wd, ref_ext(cnf, sgn, ld_data)});
        exp_mem_q.push_back({1'b0, cnf, addr, 32'h0});
        ld_data_q.push_back(ld_data);
      end
    end else begin
      fail_now("stall_timeout");
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_mem_q.size() != 0 || mreq_o) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_mreq();
    int n = 0;
    while (!mreq_o && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) fail_now("mreq_timeout");
  endtask

  // scoreboard monitor for writeback results
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid_o");
        end else begin
          e = exp_q.pop_front();
          check("wb_wreg", {31'b0, wreg_o}, {31'b0, e[37]});
          if (!e[38]) begin
            check("wb_wd", {27'b0, wd_o}, {27'b0, e[36:32]});
            check("wb_wdata", wdata_o, e[31:0]);
          end
        end
      end
    end
  end

  // memory-controller responder: checks each request, answers after a delay
  initial begin
    logic [66:0] m;
    logic [31:0] a0;
    int d;
    mdone_resp = 1'b0;
    mdata_resp = '0;
    forever begin
      @(negedge clk);
      if (mreq_o === 1'b1 && !hold_off && rst === 1'b0) begin
        if (exp_mem_q.size() == 0) begin
          fail_now("unexpected_mreq");
        end else begin
          m = exp_mem_q.pop_front();
          check("req_wr", {31'b0, mwr_o}, {31'b0, m[66]});
          check("req_cnf", {30'b0, mcnf_o}, {30'b0, m[65:64]});
          check("req_addr", maddr_o, m[63:32]);
          if (m[66]) check("req_data", mdata_o, m[31:0]);
        end
        if (!mwr_o && ld_data_q.size() > 0) mdata_resp = ld_data_q.pop_front();
        else mdata_resp = $urandom;
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        a0 = maddr_o;
        repeat (d) @(negedge clk);
        check("req_addr_stable", maddr_o, a0);
        check("req_held", {31'b0, mreq_o}, 32'd1);
        mdone_resp = 1'b1;
        @(negedge clk);
        mdone_resp = 1'b0;
      end
    end
  end

  // main sequence
  initial begin
    int kind;
    rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    memaddr_i = '0; memwr_i = 1'b0; memcnf_i = 2'd0; memsigned_i = 1'b0;
    mdone_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    valid_i = 1'b1; memcnf_i = 2'd3; memwr_i = 1'b0;
    @(negedge clk);
    check("stall_in_reset", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; memcnf_i = 2'd0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_o", {31'b0, valid_o}, 32'd0);
    check("rst_mreq_o", {31'b0, mreq_o}, 32'd0);
    check("rst_wdata_o", wdata_o, 32'd0);
    check("rst_maddr_o", maddr_o, 32'd0);
    check("rst_mcnf_o", {30'b0, mcnf_o}, 32'd0);
    check("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
    hold_off = 1'b0;
    @(posedge clk); #1;

    // ALU op passthrough
    issue(2'd0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    @(negedge clk);
    check("alu_mreq", {31'b0, mreq_o}, 32'd0);
    @(posedge clk); #1;

    // load extension
    issue(2'd1, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0, 32'h40, 32'h0000_0080);
    issue(2'd2, 1'b0, 1'b0, 5'd4, 1'b1, 32'h0, 32'h42, 32'h0001_8001);
    wait_idle();

    // store then load to the same address: load request must follow store
    issue(2'd3, 1'b1, 1'b0, 5'd1, 1'b0, 32'hCAFE_F00D, 32'h100, 32'h0);
    issue(2'd3, 1'b0, 1'b0, 5'd6, 1'b1, 32'h0, 32'h100, 32'hCAFE_F00D);
    wait_idle();

    // fill the buffer with completions held off; fifth store must stall
    hold_off = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(2'd3, 1'b1, 1'b0, 5'd0, 1'b0, $urandom, 32'h200 + 32'(i * 4), 32'h0);
    valid_i = 1'b1; memwr_i = 1'b1; memcnf_i = 2'd3; memaddr_i = 32'h210;
    @(negedge clk);
    check("sb_full_stall", {31'b0, mem_stall}, 32'd1);
    hold_off = 1'b0;
    @(posedge clk); #1;
    issue(2'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h5555_AAAA, 32'h210, 32'h0);
    wait_idle();

    // store completion and non-memory op in the same cycle
    hold_off = 1'b1;
    issue(2'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h7777_0000, 32'h300, 32'h0);
    wait_mreq();
    @(posedge clk); #1;
    fixed_delay = 0;
    hold_off = 1'b0;
    issue(2'd0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h55AA, 32'h0, 32'h0);
    @(negedge clk);
    check("st_dequeued_mreq", {31'b0, mreq_o}, 32'd0);
    fixed_delay = -1;
    wait_idle();

    // reset while a load is outstanding; a late completion is ignored
    hold_off = 1'b1;
    issue(2'd3, 1'b0, 1'b0, 5'd7, 1'b1, 32'h0, 32'h400, 32'h1111_2222);
    wait_mreq();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); exp_mem_q.delete(); ld_data_q.delete();
    @(negedge clk);
    check("rst_ld_mreq", {31'b0, mreq_o}, 32'd0);
    check("rst_ld_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk); #1;
    mdone_man = 1'b1;
    @(posedge clk); #1;
    mdone_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_mdone_valid", {31'b0, valid_o}, 32'd0);
      check("late_mdone_mreq", {31'b0, mreq_o}, 32'd0);
    end

    // reset discards pending stores: nothing drains afterwards
    @(posedge clk); #1;
    issue(2'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'hA, 32'h500, 32'h0);
    issue(2'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'hB, 32'h504, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); exp_mem_q.delete(); ld_data_q.delete();
    hold_off = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_discard_mreq", {31'b0, mreq_o}, 32'd0);
    end
    @(posedge clk); #1;

    // random traffic
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0: issue(2'd0, 1'b0, 1'b0, 5'($urandom), 1'($urandom), $urandom, 32'h0, 32'h0);
        1: issue(2'($urandom_range(1, 3)), 1'b1, 1'b0, 5'($urandom), 1'($urandom),
                 $urandom, $urandom, 32'h0);
        default: issue(2'($urandom_range(1, 3)), 1'b0, 1'($urandom), 5'($urandom),
                       1'($urandom), 32'h0, $urandom, $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    if (ld_data_q.size() != 0) fail_now("leftover_load_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
